id_early_fwd_ctrl: RTL
======================

Name: id_early_fwd_ctrl

Overview:
- Parametrised ID-stage forwarding and hazard controller for operands consumed early in decode, such as branch compare and optional JALR base.
- Keeps its own shadow scoreboard of in-flight destinations (EX, MEM, WB, and further stages if DEPTH grows).
- Each cycle it produces a per-source forward-select and an ID stall request.
- Sits beside the decoder. It replaces the fixed two-source, MEM/WB-only compare with a generalised, stall-aware unit.

Parameters:
- NUM_SRC, 2, number of early-read source operands.
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID; stage 1 = EX, stage DEPTH = WB.
- ALU_READY, 2, first stage whose ALU result can be forwarded.
- LOAD_READY, 3, first stage whose load data can be forwarded.
- JALR_EARLY, 1, when 1, JALR rs1 (source 0) is also resolved early.
- CNT_W, 16, stall counter width.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- id_valid, in, 1, ID holds a real instruction.
- id_opcode, in, 7, ID opcode (RV32 encodings).
- id_rs, in, NUM_SRC*REG_AW, source addresses; source s occupies bits [s*REG_AW +: REG_AW].
- id_rd, in, REG_AW, ID destination.
- id_regwrite, in, 1, ID instruction writes rd.
- id_is_load, in, 1, ID instruction's writeback comes from memory.
- hold, in, 1, global pipeline freeze; scoreboard does not move.
- flush, in, 1, squash the ID instruction (branch taken, trap).
- fwd_sel, out, NUM_SRC*SW, SW = clog2(DEPTH+1); 0 = register file, k = stage k result.
- id_stall, out, 1, ID must hold; a bubble enters EX.
- stall_count, out, CNT_W, saturating count of cycles with id_stall=1.

Behaviour:
- **Scoreboard.** Entries e[1..DEPTH], each {v, rd, wr, ld}. All cleared on rst.
- **Advance.** Every cycle with hold=0:
  - e[k+1] <= e[k].
  - e[1] <= {id_valid & ~flush & ~id_stall, id_rd, id_regwrite, id_is_load}.
  - A stalled or flushed ID inserts a bubble (v=0) into EX.
- **Hold.** hold=1 freezes all entries and stall_count. Outputs still track the inputs combinationally.
- **Early sources.**
  - Opcode BRANCH (1100011): all sources are early.
  - Opcode JALR (1100111) with JALR_EARLY=1: source 0 only.
  - Otherwise no source is early: fwd_sel=0 and no stall from that source.
- **Match.** Source s matches stage k when all hold: e[k].v, e[k].wr, e[k].rd == rs_s, and rs_s != 0. The youngest (lowest k) match wins; older matches are ignored.
- **Ready stage.** Winning stage k is ready if k >= (e[k].ld ? LOAD_READY : ALU_READY).
  - Ready: fwd_sel_s = k.
  - Not ready: stall is requested and fwd_sel_s = 0.
- **Stall.** id_stall = id_valid & ~flush & OR over sources of their stall requests.
  - Combinational; zero latency from the inputs.
  - fwd_sel is also combinational from the inputs and the registered scoreboard.
- **Flush.** flush=1 forces id_stall=0 and all fwd_sel=0 in that cycle.
- **Stall counter.** Increments on each cycle with id_stall=1 and hold=0. Saturates at all-ones and never wraps.
- **Reset values.** After rst: scoreboard empty, fwd_sel=0, id_stall=0, stall_count=0.
  - rst asserted mid-stall clears the stall on the next cycle.
  - rst has priority over hold and flush.
- **Simultaneous events.** rst > flush > stall. hold and stall together: stall is reported, but the scoreboard does not change.
- **Loop bounds.** All loops are bounded by the parameters; no hardcoded 2 or 3.

Test Plan:
- **ALU producer in MEM.** add x5 (ALU) enters; next cycle filler; then beq x5,x6 in ID → in that cycle e[2].rd=5 → fwd_sel[0]=2, fwd_sel[1]=0, id_stall=0.
- **Back-to-back ALU.** add x5 then immediately beq x5,x0 → cycle 1: id_stall=1, fwd_sel=0. Cycle 2 (bubble in EX, add in MEM): stall=0, fwd_sel[0]=2. stall_count=1.
- **Load-use.** lw x7 then bne x7,x7 → stall for 2 cycles; then fwd_sel[0]=fwd_sel[1]=3 from WB; stall_count=2.
- **Youngest match and x0.** add x3 into WB, add x3 into MEM, then beq x3,x0 → fwd_sel[0]=2. A writer with rd=x0 is never forwarded (source s=1 gives sel=0).
- **JALR and non-branch.** jalr x1,0(x9) with x9 in MEM → fwd_sel[0]=2. Same hazard with opcode ADD (0110011) → fwd_sel=0, id_stall=0.
- **Control events.** hold=1 for 3 cycles during a stall → scoreboard and stall_count frozen. flush=1 → id_stall=0. rst mid-stall → next cycle all outputs 0. Counter with CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/id_early_fwd_ctrl.sv
// ============================================================================
// Module   : id_early_fwd_ctrl
// Purpose  : ID-stage forwarding select and stall control for operands read
//            early in decode (branch compare, optional JALR base).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_early_fwd_ctrl #(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int JALR_EARLY = 1,
  parameter int CNT_W      = 16,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [6:0]                id_opcode,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      hold,
  input  logic                      flush,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  output logic                      id_stall,
  output logic [CNT_W-1:0]          stall_count
);

  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;

  // Shadow scoreboard, index 1 = EX ... DEPTH = WB
  logic [DEPTH:1]    v_q, v_d;
  logic [DEPTH:1]    wr_q, wr_d;
  logic [DEPTH:1]    ld_q, ld_d;
  logic [REG_AW-1:0] rd_q [1:DEPTH];
  logic [REG_AW-1:0] rd_d [1:DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC-1:0]    w_early;
  logic [NUM_SRC-1:0]    w_req;
  logic [NUM_SRC*SW-1:0] w_sel;
  logic                  w_hit;
  logic                  w_hit_ld;
  int                    w_hit_k;

  always_comb begin
    w_early  = '0;
    w_req    = '0;
    w_sel    = '0;
    w_hit    = 1'b0;
    w_hit_ld = 1'b0;
    w_hit_k  = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_early[s] = (id_opcode == C_OP_BRANCH) ||
                   ((JALR_EARLY != 0) && (id_opcode == C_OP_JALR) && (s == 0));
      w_hit    = 1'b0;
      w_hit_ld = 1'b0;
      w_hit_k  = 0;
      // Scan oldest to youngest so the youngest match overwrites older ones
      for (int k = DEPTH; k >= 1; k--) begin
        if (v_q[k] && wr_q[k] && (rd_q[k] == id_rs[s*REG_AW +: REG_AW]) &&
            (id_rs[s*REG_AW +: REG_AW] != '0)) begin
          w_hit    = 1'b1;
          w_hit_ld = ld_q[k];
          w_hit_k  = k;
        end
      end
      if (w_early[s] && w_hit) begin
        if (w_hit_k >= (w_hit_ld ? LOAD_READY : ALU_READY)) begin
          w_sel[s*SW +: SW] = SW'(w_hit_k);
        end else begin
          w_req[s] = 1'b1;
        end
      end
    end
  end

  assign id_stall    = id_valid & ~flush & (|w_req);
  assign fwd_sel     = flush ? '0 : w_sel;
  assign stall_count = cnt_q;

  always_comb begin
    v_d   = v_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_d[k]  = v_q[k-1];
        wr_d[k] = wr_q[k-1];
        ld_d[k] = ld_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      // A stalled or squashed ID leaves a bubble in EX
      v_d[1]  = id_valid & ~flush & ~id_stall;
      wr_d[1] = id_regwrite;
      ld_d[1] = id_is_load;
      rd_d[1] = id_rd;
      if (id_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire
